// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding / interlock unit.
// Shadow entries use fixed field widths so one struct serves every parameterisation.
package fwd_pkg;

   // Upper bounds on the register address width and on id_lat.
   localparam int unsigned SH_RD_W  = 8;
   localparam int unsigned SH_LAT_W = 4;

   localparam int unsigned FWD_SEL_RF  = 0;
   localparam int unsigned FWD_SEL_MEM = 1;
   localparam int unsigned FWD_SEL_WB  = 2;

   typedef struct packed {
      logic                valid;
      logic [SH_RD_W-1:0]  rd;
      logic                regwrite;
      logic [SH_LAT_W-1:0] lat;
   } shadow_entry_t;

   function automatic int unsigned sel_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   function automatic int unsigned lat_w(input int unsigned n);
      return ($clog2(n) > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/operand_resolver.sv
// Per-operand producer search over the shadow pipeline: youngest match wins,
// yielding a stall request and the forward select to register for EX.
module operand_resolver
   import fwd_pkg::*;
#(
   parameter int unsigned NUM_FWD_STAGES = 2,
   parameter int unsigned REG_AW         = 5,
   parameter int unsigned SEL_W          = 2
) (
   input  logic [REG_AW-1:0] rs,
   input  logic              rs_used,
   input  shadow_entry_t     sh [NUM_FWD_STAGES+1],
   output logic [SEL_W-1:0]  sel,
   output logic              need_stall
);

   logic found;
   int   win;
   int   win_lat;

   always_comb begin
      found   = 1'b0;
      win     = 0;
      win_lat = 0;
      // Scan oldest to youngest so the lowest matching stage is what remains.
      for (int p = int'(NUM_FWD_STAGES); p >= 0; p--) begin
         if (rs_used && (rs != '0) && sh[p].valid && sh[p].regwrite &&
             (sh[p].rd == SH_RD_W'(rs))) begin
            found   = 1'b1;
            win     = p;
            win_lat = int'(sh[p].lat);
         end
      end
   end

   always_comb begin
      need_stall = 1'b0;
      sel        = SEL_W'(FWD_SEL_RF);
      if (found) begin
         // Result exists from stage lat+1; consumer meets producer at win+1.
         need_stall = (win < win_lat);
         if (win != int'(NUM_FWD_STAGES)) begin
            sel = SEL_W'(win + 1);
         end
      end
   end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand forwarding and load-use interlock for the in-order integer pipeline.
// Tracks in-flight destinations in a shadow shift register from EX to the last stage.
module forwarding_hazard_unit
   import fwd_pkg::*;
#(
   parameter  int unsigned NUM_SRC        = 2,
   parameter  int unsigned NUM_FWD_STAGES = 2,
   parameter  int unsigned REG_AW         = 5,
   parameter  int unsigned CNT_W          = 32,
   localparam int unsigned SEL_W          = sel_w(NUM_FWD_STAGES),
   localparam int unsigned LAT_W          = lat_w(NUM_FWD_STAGES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     id_valid,
   input  logic [NUM_SRC*REG_AW-1:0] id_rs,
   input  logic [NUM_SRC-1:0]       id_rs_used,
   input  logic [REG_AW-1:0]        id_rd,
   input  logic                     id_regwrite,
   input  logic [LAT_W-1:0]         id_lat,
   output logic                     stall,
   output logic [NUM_SRC*SEL_W-1:0] ex_fwd_sel,
   output logic [CNT_W-1:0]         stall_count
);

   shadow_entry_t              sh [NUM_FWD_STAGES+1];
   shadow_entry_t              id_entry;
   logic [NUM_SRC*SEL_W-1:0]   sel_vec;
   logic [NUM_SRC-1:0]         need;
   logic                       issue;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_res
      operand_resolver #(
         .NUM_FWD_STAGES (NUM_FWD_STAGES),
         .REG_AW         (REG_AW),
         .SEL_W          (SEL_W)
      ) u_res (
         .rs         (id_rs[i*REG_AW +: REG_AW]),
         .rs_used    (id_rs_used[i]),
         .sh         (sh),
         .sel        (sel_vec[i*SEL_W +: SEL_W]),
         .need_stall (need[i])
      );
   end

   always_comb begin
      stall             = id_valid & ~flush & (|need);
      issue             = id_valid & ~stall & ~flush;
      id_entry          = '0;
      id_entry.valid    = 1'b1;
      id_entry.rd       = SH_RD_W'(id_rd);
      id_entry.regwrite = id_regwrite;
      id_entry.lat      = SH_LAT_W'(id_lat);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= int'(NUM_FWD_STAGES); k++) begin
            sh[k] <= '0;
         end
         ex_fwd_sel  <= '0;
         stall_count <= '0;
      end else begin
         // No backpressure behind EX: the shadow always advances.
         for (int k = 0; k < int'(NUM_FWD_STAGES); k++) begin
            sh[k+1] <= sh[k];
         end
         sh[0]      <= issue ? id_entry : '0;
         ex_fwd_sel <= issue ? sel_vec : '0;
         if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Parametrised operand-forwarding and interlock unit for the in-order integer pipeline.
- Keeps its own shadow of in-flight destination registers, one entry per stage (EX onward).
- From ID, for each of NUM_SRC source operands it decides one of three things: stall (producer not yet ready), forward from a named later stage, or read the register file.
- The forward select is registered so that it is aligned with EX. The unit replaces the per-stage combinational compare units; variable producer latency (ALU, load, longer) is handled by the stall logic.

Parameters:
- NUM_SRC, 2, source operands per instruction (rs1, rs2, ...).
- NUM_FWD_STAGES, 2, forwardable stages after EX (1=MEM, 2=WB, ...).
- REG_AW, 5, register address width.
- CNT_W, 32, width of the stall performance counter.
- Derived: SEL_W=$clog2(NUM_FWD_STAGES+1); LAT_W=max(1,$clog2(NUM_FWD_STAGES)).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  squash the instruction currently in ID.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  NUM_SRC*REG_AW  source register addresses; operand i is at [i*REG_AW +: REG_AW].
- id_rs_used  in  NUM_SRC  per-operand "operand is actually read".
- id_rd  in  REG_AW  destination register.
- id_regwrite  in  1  instruction writes id_rd.
- id_lat  in  LAT_W  producer class: 0 = ALU, 1 = load, k = result forwardable from stage k+1; legal range 0..NUM_FWD_STAGES-1.
- stall  out  1  hold IF/ID this cycle and insert a bubble into EX.
- ex_fwd_sel  out  NUM_SRC*SEL_W  per-operand select for EX: 0 = pipeline register/RF, s = stage s (1=MEM, 2=WB, ...).
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Shadow structure:
  - sh[0..NUM_FWD_STAGES], with sh[0]=EX and sh[N]=last stage (WB at default).
  - Each entry holds {valid, rd, regwrite, lat}.
- Shadow advance:
  - Every cycle, sh[k+1] <= sh[k] for all k, unconditionally; the pipeline has no backpressure behind EX.
  - sh[N] retires to the register file. The register file is write-through, so a same-cycle ID read sees the retiring value.
- Issue into EX:
  - If id_valid & !stall & !flush: sh[0] <= {1, id_rd, id_regwrite, id_lat}.
  - Otherwise sh[0].valid <= 0 (bubble).
- Producer match for operand i (combinational, in ID):
  - A match requires: id_rs_used[i]; id_rs[i] != 0; sh[p].valid; sh[p].regwrite; sh[p].rd == id_rs[i].
  - The youngest match (lowest p) wins. Older matches are ignored.
- Readiness and select for the winning producer at p:
  - Stall if p < sh[p].lat. When the consumer reaches EX, the producer will sit at p+1, but its result exists only from stage lat+1.
  - If p == N: no forwarding needed, select = 0.
  - Otherwise the select registered for EX is p+1.
  - No match: select = 0.
- stall output:
  - stall = id_valid & !flush & OR over operands of (operand needs stall).
  - Combinational. Reset value 0, since all shadow entries are invalid after reset.
- ex_fwd_sel update:
  - Registered. Loaded with the computed selects when issuing.
  - Loaded with all zeros on a bubble, stall, or flush.
  - Reset value 0.
- stall_count:
  - Increments by 1 on each cycle with stall=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Reset value 0.
- Latency: stall is same-cycle (combinational from ID); ex_fwd_sel is valid 1 cycle later, aligned with EX.
- Default configuration: an ALU producer in EX gives sel=1 to the dependent instruction, with no stall. A load in EX gives 1 stall cycle, then sel=2.
- Boundaries:
  - Register x0 never matches, regardless of regwrite.
  - flush and stall conditions in the same cycle: flush wins. stall=0, counter unchanged, bubble inserted.
  - Operand with id_rs_used=0: never stalls, select=0.
  - Multiple operands naming the same register: each is resolved independently, giving identical selects.
  - id_lat outside the legal range: the result is undefined.
  - rst asserted mid-operation: all shadow entries invalid, ex_fwd_sel=0, stall_count=0 on the next edge. stall drops in the same cycle that shadow.valid clears.

Decomposition:
- Shared package fwd_pkg holds:
  - shadow_entry_t struct {valid, rd, regwrite, lat};
  - FWD_SEL_RF=0, FWD_SEL_MEM=1, FWD_SEL_WB=2 constants;
  - the sel_w/lat_w helper functions.
- Sub-module operand_resolver, instantiated NUM_SRC times, computes the per-operand match, select and stall.

Test Plan:
- ALU chain, default params:
  - add x5 issued (lat0), next instruction reads x5 on rs1.
  - Expect stall=0 and ex_fwd_sel[0]=1 the cycle after.
  - Third instruction reading x5 expects sel=2.
- Load-use:
  - lw x6 (lat1) followed by a consumer of x6 on rs2.
  - Expect stall=1 for exactly 1 cycle, a bubble in sh[0], then ex_fwd_sel[1]=2.
  - stall_count=1.
- x0 and unused operands:
  - Producer writes x0 with lat1; consumer reads x0.
  - Then a consumer with id_rs_used=0 on a pending load register.
  - Expect stall=0 and sel=0 in both cases.
- Youngest wins:
  - x7 written by instruction A (now in MEM) and by instruction B (now in EX); consumer reads x7.
  - Expect sel=1, selecting B.
  - Second case: producer in WB only at ID time gives sel=0 (write-through).
- Flush versus stall:
  - Load-use hazard present with flush=1 in the same cycle.
  - Expect stall=0, stall_count unchanged, sh[0] bubble, ex_fwd_sel=0.
- Reset and saturation:
  - Assert rst mid-hazard: stall=0 and sel=0 next cycle.
  - With CNT_W=3, drive 10 stall cycles: stall_count holds 7.
